// File: rtl/pe1_pkg.sv
// Shared PE1 multiplier constants and the carry-save pair type that the
// level-2 Dadda tree hands to the final carry-propagate stage.
package pe1_pkg;

    localparam int PE1_DT_W     = 15;
    localparam int PE1_CPA_LO_W = 8;

    typedef struct packed {
        logic [PE1_DT_W-1:0] s;
        logic [PE1_DT_W-1:0] c;
    } pe1_cs_pair_t;

endpackage

// File: rtl/dt_cpa_seg.sv
// Combinational N-bit ripple segment with carry-in and carry-out; used as the
// low and high halves of the split adder, or as the full-width adder.
module dt_cpa_seg #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

endmodule

// File: rtl/dt_cpa_pipe.sv
// Final carry-propagate stage after the Dadda tree: (s + c) mod 2^W with a
// valid/ready handshake. Define DT_CPA_SINGLE_STAGE_EN for a one-stage adder.
module dt_cpa_pipe
    import pe1_pkg::*;
#(
    parameter int W    = PE1_DT_W,
    parameter int LO_W = PE1_CPA_LO_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] s,
    input  logic [W-1:0] c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
);

    logic         s2_v_q, s2_v_d;
    logic [W-1:0] result_q, result_d;
    logic         s2_free;
    logic         in_xfer;

    assign s2_free = !s2_v_q || out_ready;

`ifdef DT_CPA_SINGLE_STAGE_EN

    logic [W-1:0] full_sum;
    logic         full_co;

    // Carry out of the MSB is the tree's discarded column carry.
    dt_cpa_seg #(.N(W)) u_seg_full (
        .a   (s),
        .b   (c),
        .ci  (1'b0),
        .sum (full_sum),
        .co  (full_co)
    );

    assign in_ready = s2_free;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        s2_v_d   = s2_v_q;
        result_d = result_q;
        if (in_xfer) begin
            s2_v_d   = 1'b1;
            result_d = full_sum;
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end
    end

`else

    localparam int HI_W = W - LO_W;

    logic              s1_v_q, s1_v_d;
    logic [LO_W-1:0]   lo_q, lo_d;
    logic              cy_q, cy_d;
    logic [HI_W-1:0]   s_hi_q, s_hi_d;
    logic [HI_W-1:0]   c_hi_q, c_hi_d;
    logic [LO_W-1:0]   lo_sum;
    logic              lo_co;
    logic [HI_W-1:0]   hi_sum;
    logic              hi_co;
    logic              s1_adv;

    dt_cpa_seg #(.N(LO_W)) u_seg_lo (
        .a   (s[LO_W-1:0]),
        .b   (c[LO_W-1:0]),
        .ci  (1'b0),
        .sum (lo_sum),
        .co  (lo_co)
    );

    // High half finishes one cycle later using the registered low carry.
    dt_cpa_seg #(.N(HI_W)) u_seg_hi (
        .a   (s_hi_q),
        .b   (c_hi_q),
        .ci  (cy_q),
        .sum (hi_sum),
        .co  (hi_co)
    );

    assign s1_adv   = s1_v_q && s2_free;
    assign in_ready = !s1_v_q || s2_free;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        s1_v_d = s1_v_q;
        lo_d   = lo_q;
        cy_d   = cy_q;
        s_hi_d = s_hi_q;
        c_hi_d = c_hi_q;
        if (in_xfer) begin
            s1_v_d = 1'b1;
            lo_d   = lo_sum;
            cy_d   = lo_co;
            s_hi_d = s[W-1:LO_W];
            c_hi_d = c[W-1:LO_W];
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
    end

    always_comb begin
        s2_v_d   = s2_v_q;
        result_d = result_q;
        if (s1_adv) begin
            s2_v_d   = 1'b1;
            result_d = {hi_sum, lo_q};
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v_q <= 1'b0;
            lo_q   <= '0;
            cy_q   <= 1'b0;
            s_hi_q <= '0;
            c_hi_q <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            lo_q   <= lo_d;
            cy_q   <= cy_d;
            s_hi_q <= s_hi_d;
            c_hi_q <= c_hi_d;
        end
    end

`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_v_q   <= 1'b0;
            result_q <= '0;
        end else begin
            s2_v_q   <= s2_v_d;
            result_q <= result_d;
        end
    end

    assign out_valid = s2_v_q;
    assign result    = result_q;

endmodule
